// File: rtl/route_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : route_sequencer_pkg
// Description : Shared definitions for the route sequencer slice: drive
//               command codes sent to the motor block, sequencer state
//               encodings (also exported on the debug state port) and the
//               index of the final leg of a mission.
// Revision    : 1.0 - initial release
// ============================================================================
package route_sequencer_pkg;

  // Drive command codes understood by the motor block.
  typedef enum logic [2:0] {
    DRIVE_Stop     = 3'd0,
    DRIVE_Straight = 3'd1,
    DRIVE_Left     = 3'd2,
    DRIVE_Right    = 3'd3,
    DRIVE_Reverse  = 3'd4
  } drive_e;

  // Sequencer states; the numeric values are visible on the debug port.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RUN    = 3'd1,
    GAP    = 3'd2,
    FINISH = 3'd3,
    FAULT  = 3'd4
  } state_e;

  // A mission is four legs, numbered 0..3.
  localparam logic [1:0] LAST_LEG = 2'd3;

endpackage : route_sequencer_pkg
`default_nettype wire

// File: rtl/route_sequencer_route_table.sv
`default_nettype none
// ============================================================================
// Module      : route_table
// Description : Combinational route lookup. Maps the latched target position
//               and the current leg index to the drive command for that leg.
//               Only leg 1 depends on the target; the other legs are fixed.
// Ports       : target  in  2  target position (1..3 valid)
//               leg_idx in  2  leg index 0..3
//               route   out 3  drive command code
// Revision    : 1.0 - initial release
// ============================================================================
module route_table
  import route_sequencer_pkg::*;
(
  input  logic [1:0] target,
  input  logic [1:0] leg_idx,
  output logic [2:0] route
);

  always_comb begin
    route = DRIVE_Stop;
    case (leg_idx)
      2'd0: route = DRIVE_Straight;
      2'd1: begin
        case (target)
          2'd1:    route = DRIVE_Left;
          2'd2:    route = DRIVE_Straight;
          2'd3:    route = DRIVE_Right;
          // Target 0 is never latched; stop is the safe answer anyway.
          default: route = DRIVE_Stop;
        endcase
      end
      2'd2:    route = DRIVE_Straight;
      default: route = DRIVE_Reverse;
    endcase
  end

endmodule : route_table
`default_nettype wire

// File: rtl/route_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : route_sequencer
// Description : Mission sequencer for a four-leg drive route. A valid start
//               latches the target and walks legs 0..3, issuing one drive
//               command per leg and a one-cycle stop gap between legs. A
//               one-cycle done pulse closes the mission. abort (and the
//               optional leg timeout) force a sticky FAULT that is left only
//               by a new valid start.
//               All outputs are registered and change on the same edge as
//               the state: every output is derived from the next state.
// Optional    : ROUTE_SEQ_TIMEOUT_EN - adds a per-leg cycle counter; a leg
//               still active after TIMEOUT_CYCLES cycles goes to FAULT.
// Parameters  : TIMEOUT_CYCLES  max cycles one leg may stay in RUN
//               CNT_W           timeout counter width, 2^CNT_W > TIMEOUT_CYCLES
// Ports       : clk        in  1  system clock, rising edge
//               rst        in  1  synchronous active-high reset
//               start      in  1  mission request (IDLE / FAULT only)
//               target_pos in  2  target position, 1..3 valid
//               leg_done   in  1  pulse: current leg complete
//               abort      in  1  level: force FAULT from RUN / GAP
//               route_req  out 3  drive command to the motor block
//               pwm_go     out 1  motor enable
//               leg_idx    out 2  current leg 0..3
//               busy       out 1  high in RUN and GAP
//               done       out 1  one-cycle mission-complete pulse
//               error      out 1  sticky fault flag
//               state      out 3  state encoding for debug display
// Revision    : 1.0 - initial release
// ============================================================================
module route_sequencer
  import route_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 200_000_000,
  parameter int CNT_W          = 28
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] target_pos,
  input  logic       leg_done,
  input  logic       abort,
  output logic [2:0] route_req,
  output logic       pwm_go,
  output logic [1:0] leg_idx,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state
);

  state_e     state_q,     state_d;
  logic [1:0] target_q,    target_d;
  logic [1:0] leg_idx_q,   leg_idx_d;
  logic [2:0] route_req_q, route_req_d;
  logic       pwm_go_q,    pwm_go_d;
  logic       busy_q,      busy_d;
  logic       done_q,      done_d;
  logic       error_q,     error_d;

  logic [2:0] route_nxt;
  logic       timeout_hit;

  // Looked up with the next-state target/leg so the registered route_req
  // lines up with the state it belongs to.
  route_table u_route_table (
    .target  (target_d),
    .leg_idx (leg_idx_d),
    .route   (route_nxt)
  );

`ifdef ROUTE_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign timeout_hit = (tmo_cnt_q == TMO_LAST);

  // Counts consecutive cycles of one leg; any transition into RUN (from
  // IDLE, GAP or FAULT) starts again from zero.
  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == RUN) && (state_d == RUN)) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  // Without the timeout a leg waits indefinitely for leg_done or abort.
  assign timeout_hit = 1'b0;

  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES[0], CNT_W[0]};
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    leg_idx_d = leg_idx_q;
    error_d   = error_q;

    case (state_q)
      IDLE, FAULT: begin
        if (start) begin
          if (target_pos != 2'd0) begin
            target_d  = target_pos;
            leg_idx_d = 2'd0;
            error_d   = 1'b0;
            state_d   = RUN;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      RUN: begin
        // abort outranks a leg_done arriving in the same cycle, and
        // leg_done outranks a timeout expiring in the same cycle.
        if (abort) begin
          state_d = FAULT;
        end else if (leg_done) begin
          if (leg_idx_q == LAST_LEG) begin
            state_d = FINISH;
          end else begin
            leg_idx_d = leg_idx_q + 2'd1;
            state_d   = GAP;
          end
        end else if (timeout_hit) begin
          state_d = FAULT;
        end
      end
      GAP: begin
        state_d = abort ? FAULT : RUN;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d == FAULT) begin
      error_d = 1'b1;
    end

    pwm_go_d    = (state_d == RUN);
    busy_d      = (state_d == RUN) || (state_d == GAP);
    done_d      = (state_d == FINISH);
    route_req_d = (state_d == RUN) ? route_nxt : DRIVE_Stop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      target_q    <= 2'd0;
      leg_idx_q   <= 2'd0;
      route_req_q <= DRIVE_Stop;
      pwm_go_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      leg_idx_q   <= leg_idx_d;
      route_req_q <= route_req_d;
      pwm_go_q    <= pwm_go_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign route_req = route_req_q;
  assign pwm_go    = pwm_go_q;
  assign leg_idx   = leg_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign state     = state_q;

endmodule : route_sequencer
`default_nettype wire

// File: tb/tb_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_route_sequencer
// Description : Self-checking bench for route_sequencer. Expected drive
//               commands are queued as missions are started and compared
//               when the DUT raises pwm_go for each leg.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_route_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] target_pos;
  logic       leg_done;
  logic       abort;
  logic [2:0] route_req;
  logic       pwm_go;
  logic [1:0] leg_idx;
  logic       busy;
  logic       done;
  logic       error;
  logic [2:0] state;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_cnt = 0;
  int unsigned exp_done = 0;
  logic        pwm_prev = 1'b0;
  logic [2:0]  exp_q[$];

  always #5 clk = ~clk;

  route_sequencer #(
`ifdef ROUTE_SEQ_TIMEOUT_EN
    .TIMEOUT_CYCLES (16),
    .CNT_W          (5)
`else
    .TIMEOUT_CYCLES (1000),
    .CNT_W          (10)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .target_pos (target_pos),
    .leg_done   (leg_done),
    .abort      (abort),
    .route_req  (route_req),
    .pwm_go     (pwm_go),
    .leg_idx    (leg_idx),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .state      (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference route: legs 0/2 straight, leg 3 reverse, leg 1 by target.
  function automatic logic [2:0] exp_route(input int tgt, input int leg);
    if (leg == 0 || leg == 2) return 3'd1;
    if (leg == 3)             return 3'd4;
    case (tgt)
      1:       return 3'd2;
      2:       return 3'd1;
      default: return 3'd3;
    endcase
  endfunction

  task automatic push_mission(input int tgt);
    for (int l = 0; l < 4; l++) exp_q.push_back(exp_route(tgt, l));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int tgt);
    start      = 1'b1;
    target_pos = 2'(tgt);
    tick();
    start = 1'b0;
    check("start_state", state, 1);
    check("start_pwm", pwm_go, 1);
    check("start_busy", busy, 1);
    check("start_leg_idx", leg_idx, 0);
    check("start_error", error, 0);
  endtask

  // Runs one leg lasting 10 cycles; optionally fires stray start pulses
  // with a different target during RUN, GAP and FINISH.
  task automatic run_leg(input int tgt, input int leg, input bit glitch);
    for (int i = 0; i < 9; i++) begin
      if (glitch && i == 3) begin
        start      = 1'b1;
        target_pos = 2'd3;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("run_route", route_req, exp_route(tgt, leg));
    leg_done = 1'b1;
    tick();
    leg_done = 1'b0;
    if (leg < 3) begin
      check("gap_state", state, 2);
      check("gap_pwm", pwm_go, 0);
      check("gap_route", route_req, 0);
      check("gap_leg_idx", leg_idx, 32'(leg + 1));
      check("gap_busy", busy, 1);
      if (glitch) begin
        start      = 1'b1;
        target_pos = 2'd3;
      end
      tick();
      start = 1'b0;
      check("rerun_state", state, 1);
      check("rerun_pwm", pwm_go, 1);
    end else begin
      check("fin_state", state, 3);
      check("fin_done", done, 1);
      check("fin_pwm", pwm_go, 0);
      check("fin_leg_idx", leg_idx, 3);
      exp_done++;
      if (glitch) begin
        start      = 1'b1;
        target_pos = 2'd3;
      end
      tick();
      start = 1'b0;
      check("post_state", state, 0);
      check("post_done", done, 0);
      check("post_leg_idx", leg_idx, 3);
      check("post_pwm", pwm_go, 0);
    end
  endtask

  task automatic run_mission(input int tgt, input bit glitch);
    push_mission(tgt);
    do_start(tgt);
    for (int l = 0; l < 4; l++) run_leg(tgt, l, glitch);
    check("mission_done_count", done_cnt, exp_done);
  endtask

  // Scoreboard side: each rising pwm_go starts a leg whose command must
  // match the next queued expectation.
  always @(negedge clk) begin
    if (pwm_go && !pwm_prev) begin
      if (exp_q.size() != 0) check("sb_route", route_req, exp_q.pop_front());
      else                   check("sb_underflow", exp_q.size(), 1);
    end
    if (done) done_cnt <= done_cnt + 1;
    pwm_prev <= pwm_go;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst        = 1'b1;
    start      = 1'b1;
    target_pos = 2'd2;
    leg_done   = 1'b0;
    abort      = 1'b1;
    repeat (3) tick();
    // Reset must win over start and abort.
    check("rst_state", state, 0);
    check("rst_pwm", pwm_go, 0);
    check("rst_route", route_req, 0);
    check("rst_leg_idx", leg_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    rst   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tick();

    // leg_done outside RUN is ignored.
    leg_done = 1'b1;
    tick();
    leg_done = 1'b0;
    check("idle_legdone_state", state, 0);
    check("idle_legdone_leg_idx", leg_idx, 0);

    // Full mission to target 2.
    run_mission(2, 1'b0);

    // Invalid target, then a valid one clears the error.
    start      = 1'b1;
    target_pos = 2'd0;
    tick();
    start = 1'b0;
    check("bad_start_error", error, 1);
    check("bad_start_state", state, 0);
    check("bad_start_pwm", pwm_go, 0);
    run_mission(3, 1'b0);

    // abort together with leg_done during leg 1.
    exp_q.push_back(exp_route(1, 0));
    exp_q.push_back(exp_route(1, 1));
    do_start(1);
    run_leg(1, 0, 1'b0);
    repeat (3) tick();
    abort    = 1'b1;
    leg_done = 1'b1;
    tick();
    abort    = 1'b0;
    leg_done = 1'b0;
    check("abort_state", state, 4);
    check("abort_leg_idx", leg_idx, 1);
    check("abort_pwm", pwm_go, 0);
    check("abort_route", route_req, 0);
    check("abort_error", error, 1);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (3) tick();
    check("fault_hold_state", state, 4);
    check("abort_done_count", done_cnt, exp_done);

    // Leave FAULT with a valid start; stray starts must not change target.
    run_mission(1, 1'b1);

`ifdef ROUTE_SEQ_TIMEOUT_EN
    exp_q.push_back(exp_route(1, 0));
    do_start(1);
    n = 0;
    while (state != 3'd4 && n < 100) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, 16);
    check("timeout_error", error, 1);
    check("timeout_pwm", pwm_go, 0);
`else
    push_mission(1);
    do_start(1);
    repeat (40) tick();
    check("no_timeout_state", state, 1);
    check("no_timeout_pwm", pwm_go, 1);
    n = 0;
    for (int l = 0; l < 4; l++) run_leg(1, l, 1'b0);
`endif

    // Reset during leg 2, then a normal mission two cycles later.
    for (int l = 0; l < 3; l++) exp_q.push_back(exp_route(2, l));
    do_start(2);
    run_leg(2, 0, 1'b0);
    run_leg(2, 1, 1'b0);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_state", state, 0);
    check("midrst_pwm", pwm_go, 0);
    check("midrst_route", route_req, 0);
    check("midrst_leg_idx", leg_idx, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_error", error, 0);
    tick();
    run_mission(2, 1'b0);

    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_done_count", done_cnt, exp_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_route_sequencer
`default_nettype wire

// File: doc/route_sequencer.md
ROUTE_SEQUENCER -- requirements
Module: route_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 200_000_000, maximum clk cycles one leg may stay active before a fault.
REQ-002 Parameter CNT_W, default 28, width of the leg timeout counter; SHALL satisfy 2^CNT_W > TIMEOUT_CYCLES.
REQ-003 clk  in  1  system clock, rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  mission request; sampled only in IDLE or FAULT.
REQ-006 target_pos  in  2  target position, 1..3 valid, 0 invalid; sampled with start.
REQ-007 leg_done  in  1  one-cycle pulse from the motor/distance block: current leg complete.
REQ-008 abort  in  1  level; forces FAULT from any busy state.
REQ-009 route_req  out  3  drive command code to the motor block.
REQ-010 pwm_go  out  1  motor enable.
REQ-011 leg_idx  out  2  index of the current leg, 0..3.
REQ-012 busy  out  1  high in RUN and GAP.
REQ-013 done  out  1  one-cycle mission-complete pulse.
REQ-014 error  out  1  sticky fault flag.
REQ-015 state  out  3  current state encoding, for debug display.

Function
REQ-016 States: IDLE, RUN, GAP, FINISH, FAULT; all outputs SHALL be registered and updated on the same edge as the state.
REQ-017 IDLE outputs: pwm_go=0, route_req=DRIVE_Stop, busy=0.
REQ-018 In IDLE, start=1 with target_pos 1..3 SHALL latch the target, clear leg_idx to 0, clear error and go to RUN; pwm_go is high in the cycle after start is sampled.
REQ-019 In IDLE, start=1 with target_pos=0 SHALL set error=1 and remain in IDLE.
REQ-020 Route table: leg0 DRIVE_Straight; leg1 DRIVE_Left, DRIVE_Straight or DRIVE_Right for target 1, 2 or 3; leg2 DRIVE_Straight; leg3 DRIVE_Reverse.
REQ-021 RUN outputs: pwm_go=1, route_req = table[target][leg_idx].
REQ-022 In RUN, on leg_done: if leg_idx<3, increment leg_idx and go to GAP; if leg_idx=3, go to FINISH.
REQ-023 GAP SHALL last exactly one cycle with pwm_go=0 and route_req=DRIVE_Stop, then return to RUN.
REQ-024 FINISH SHALL assert done for exactly one cycle with pwm_go=0, then go to IDLE.
REQ-025 abort=1 in RUN or GAP SHALL go to FAULT on the next edge and take priority over a simultaneous leg_done.
REQ-026 FAULT outputs: pwm_go=0, route_req=DRIVE_Stop, error=1; leave only on a valid start, which is handled as in REQ-018.
REQ-027 start while busy or in FINISH SHALL be ignored, with no change to the latched target.
REQ-028 leg_done outside RUN SHALL be ignored.
REQ-029 The leg_idx increment SHALL never wrap; leg_idx stays 3 in FINISH.

Reset
REQ-030 rst SHALL override every input including abort: state=IDLE, leg_idx=0, latched target=0, pwm_go=0, route_req=DRIVE_Stop, busy=0, done=0, error=0, timeout counter=0.
REQ-031 rst mid-mission SHALL drop pwm_go on the same edge, with no done pulse.

Configuration
REQ-032 With macro ROUTE_SEQ_TIMEOUT_EN defined:
  - the timeout counter clears on every entry to RUN and counts each RUN cycle;
  - when it reaches TIMEOUT_CYCLES-1 without leg_done, the next state is FAULT;
  - leg_done in that same cycle wins.
REQ-033 With ROUTE_SEQ_TIMEOUT_EN undefined, no counter exists and RUN waits indefinitely for leg_done or abort.

Structure
REQ-034 The shared params package SHALL hold:
  - route codes: DRIVE_Stop=0, DRIVE_Straight=1, DRIVE_Left=2, DRIVE_Right=3, DRIVE_Reverse=4;
  - state encodings: IDLE=0, RUN=1, GAP=2, FINISH=3, FAULT=4.
REQ-035 Sub-module route_table (combinational; target and leg_idx in, route code out) SHALL implement REQ-020.

Verification
REQ-036 start with target_pos=2, then leg_done every 10 cycles -> route_req sequence 1,1,1,4 with one GAP cycle between legs; done pulses once; pwm_go=0 after.
REQ-037 start with target_pos=0 -> error=1, state stays IDLE; then start with target_pos=3 -> error clears, leg1 route_req=3.
REQ-038 abort and leg_done in the same cycle during leg1 -> FAULT, leg_idx stays 1, pwm_go=0, no done.
REQ-039 With ROUTE_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, no leg_done -> FAULT exactly 16 cycles after entering RUN.
REQ-040 rst during leg2 -> all outputs at reset values on the next edge; a start 2 cycles later runs a full mission normally.
REQ-041 start pulse during RUN with a different target_pos -> ignored; the route follows the original target.
